// File: rtl/wb_pkg.sv
// Shared writeback encodings: instruction classes, register-file mux selects,
// sequencer state encodings and the memory wait timeout. Main control and the
// datapath muxes import these so every block agrees on the codes.
package wb_pkg;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'b000,
        CLS_RT_ALU = 3'b001,
        CLS_RD_ALU = 3'b010,
        CLS_LINK   = 3'b011,
        CLS_LOAD   = 3'b100,
        CLS_PUSH   = 3'b101,
        CLS_POP    = 3'b110,
        CLS_RSVD   = 3'b111
    } wb_class_e;

    // Register-write address mux select
    typedef enum logic [1:0] {
        WR_RT  = 2'b00,
        WR_R29 = 2'b01,
        WR_R31 = 2'b10,
        WR_RD  = 2'b11
    } wr_sel_e;

    // Write-data mux select
    typedef enum logic [1:0] {
        DS_ALU = 2'b00,
        DS_MEM = 2'b01,
        DS_PC4 = 2'b10,
        DS_SP  = 2'b11
    } data_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_WRITE1   = 3'd2,
        ST_WRITE2   = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef struct packed {
        wr_sel_e   wr;
        data_sel_e data;
    } wb_mux_t;

    // Number of WAIT_MEM cycles tolerated before the load is abandoned
    localparam int unsigned WAIT_TIMEOUT = 15;
    localparam int unsigned WAIT_CNT_W   = 4;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

    // Mux selects used during the first (or only) register write of a class
    function automatic wb_mux_t write1_mux(wb_class_e cls);
        wb_mux_t m;
        m.wr   = WR_RT;
        m.data = DS_ALU;
        case (cls)
            CLS_RD_ALU: m.wr = WR_RD;
            CLS_LINK: begin
                m.wr   = WR_R31;
                m.data = DS_PC4;
            end
            CLS_PUSH: begin
                m.wr   = WR_R29;
                m.data = DS_SP;
            end
            CLS_LOAD, CLS_POP: m.data = DS_MEM;
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Handshake between main control / memory and the writeback sequencer, plus
// the register-file controls the sequencer drives.
interface wb_sequencer_if;
    logic       start;
    logic [2:0] wb_class;
    logic       mem_valid;
    logic [1:0] wr_sel;
    logic [1:0] data_sel;
    logic       reg_write;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, wb_class, mem_valid,
        input  wr_sel, data_sel, reg_write, busy, done, err
    );

    modport slave (
        input  start, wb_class, mem_valid,
        output wr_sel, data_sel, reg_write, busy, done, err
    );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts one instruction at a time from main control,
// waits for load data where needed, issues one or two register-file writes
// and ends with a done pulse qualified by err (illegal class or memory timeout).
module wb_sequencer
    import wb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    wb_sequencer_if.slave  bus
);

    state_e                  state;
    state_e                  state_nxt;
    wb_class_e               cls_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    err_q;
    logic                    accept;
    logic                    timeout;
    wb_mux_t                 mux1;

    // Start is only honoured from IDLE; anything else leaves the sequence alone
    assign accept  = (state == ST_IDLE) && bus.start;
    // Timeout fires only when the last allowed wait cycle also lacks data
    assign timeout = (state == ST_WAIT_MEM) && !bus.mem_valid && (wait_cnt == WAIT_LAST);
    assign mux1    = write1_mux(cls_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched class, abort flag and WAIT_MEM cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_q    <= CLS_NONE;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                cls_q <= wb_class_e'(bus.wb_class);
                err_q <= (bus.wb_class == CLS_RSVD);
            end else if (timeout) begin
                err_q <= 1'b1;
            end

            if (state == ST_WAIT_MEM) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.wb_class)
                        CLS_NONE, CLS_RSVD: state_nxt = ST_DONE;
                        CLS_LOAD, CLS_POP:  state_nxt = ST_WAIT_MEM;
                        default:            state_nxt = ST_WRITE1;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                // Data arriving on the last wait cycle still wins over timeout
                if (bus.mem_valid) begin
                    state_nxt = ST_WRITE1;
                end else if (timeout) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WRITE1: state_nxt = (cls_q == CLS_POP) ? ST_WRITE2 : ST_DONE;
            ST_WRITE2: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode from state and latched class
    always_comb begin
        bus.reg_write = 1'b0;
        bus.wr_sel    = WR_RT;
        bus.data_sel  = DS_ALU;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.busy      = (state != ST_IDLE);
        unique case (state)
            ST_WRITE1: begin
                bus.reg_write = 1'b1;
                bus.wr_sel    = mux1.wr;
                bus.data_sel  = mux1.data;
            end
            ST_WRITE2: begin
                // Second POP write updates the stack pointer
                bus.reg_write = 1'b1;
                bus.wr_sel    = WR_R29;
                bus.data_sel  = DS_SP;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

endmodule
